// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump > branch > pending redirect > sequential.
module pc_next_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] if_pc4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              redir_pend,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc, jmp_pc, brn_pc;

  assign seq_pc = pc + ADDR_W'(4);
  // Jump region comes from the PC+4 of the instruction sitting in decode.
  assign jmp_pc = {if_pc4[ADDR_W-1 -: ADDR_W-28], jump_index, 2'b00};
  assign brn_pc = {branch_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    if (redir_pend)   next_pc = redir_pc;
    if (branch_taken) next_pc = brn_pc;
    if (jump)         next_pc = jmp_pc;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, single-outstanding imem handshake,
// redirect latch and the fetched-instruction output register.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc4
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, next_pc, redir_pc;
  logic              redir_pend, ack_fire;

  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;
  assign ack_fire  = imem_req && imem_ack;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_sel (
    .pc            (pc),
    .jump          (jump),
    .jump_index    (jump_index),
    .if_pc4        (if_pc4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redir_pend    (redir_pend),
    .redir_pc      (redir_pc),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (ack_fire) state_nxt = HOLD;
      HOLD:    if (!stall)   state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc4     <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (ack_fire) begin
        if_instr   <= imem_rdata;
        if_pc4     <= pc + ADDR_W'(4);
        if_valid   <= 1'b1;
        pc         <= next_pc;
        redir_pend <= 1'b0;
      end else begin
        if (state == HOLD && !stall) if_valid <= 1'b0;
        // With a redirect active the mux output is exactly its target.
        if (jump || branch_taken) begin
          redir_pend <= 1'b1;
          redir_pc   <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit with a queue-based scoreboard.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        branch_taken, jump, stall;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;

  logic        req1, valid1;
  logic [31:0] addr1, instr1, pc4_1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4)
  );

  // Wrap instance: zero-wait memory with ack tied to req, rdata = addr.
  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(req1), .imem_rdata(addr1),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_index(26'h0), .stall(1'b0),
    .if_valid(valid1), .if_instr(instr1), .if_pc4(pc4_1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction from FETCH (entered at a negedge) back to FETCH.
  task automatic do_fetch(input logic [31:0] a, input int lat, input int stl,
                          input logic aj, input logic ab, input logic [31:0] abt,
                          input logic sb, input logic [31:0] sbt,
                          input logic cb, input logic [31:0] cbt);
    logic [63:0] exp;
    for (int i = 0; i <= lat; i++) begin
      chk("req", 32'(imem_req), 32'd1);
      chk("addr", imem_addr, a);
      if (i == lat) begin
        imem_ack = 1'b1; imem_rdata = a;
        jump = aj; branch_taken = ab; branch_target = abt;
        sb_q.push_back({a, a + 32'd4});
      end
      @(negedge clk);
      imem_ack = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      exp = '0;
    end else exp = sb_q.pop_front();
    chk("valid", 32'(if_valid), 32'd1);
    chk("instr", if_instr, exp[63:32]);
    chk("pc4", if_pc4, exp[31:0]);
    chk("hold_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < stl; i++) begin
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      branch_taken = sb && (i == 0); branch_target = sbt;
      @(negedge clk);
      imem_ack = 1'b0; branch_taken = 1'b0;
      chk("stl_valid", 32'(if_valid), 32'd1);
      chk("stl_instr", if_instr, exp[63:32]);
      chk("stl_pc4", if_pc4, exp[31:0]);
      chk("stl_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0; branch_taken = cb; branch_target = cbt;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("cons_valid", 32'(if_valid), 32'd0);
    chk("cons_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
    jump_index = 26'h40; stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);

    // Wrap instance runs on its own while the main DUT waits in FETCH.
    rst_n = 1'b1;
    #1;
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    chk("wrap_req0", 32'(req1), 32'd1);
    @(negedge clk);
    chk("wrap_valid", 32'(valid1), 32'd1);
    chk("wrap_pc4", pc4_1, 32'h0000_0000);
    chk("wrap_instr", instr1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", addr1, 32'h0000_0000);
    chk("wrap_req1", 32'(req1), 32'd1);

    // Pass A: sequential, delayed ack with stall, delay-slot branch.
    do_fetch(32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h4,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h8,   3, 5, 0, 0, 0, 0, 0, 1, 32'h103);
    do_fetch(32'hC,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a pending fetch with a late ack in the reset cycle.
    chk("pend_addr", imem_addr, 32'h108);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_instr", if_instr, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_pc", imem_addr, 32'h0);
    chk("mid_rst_req1", 32'(imem_req), 32'd1);

    // Pass B: jump+branch at an ack, then overwritten redirect.
    do_fetch(32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h4,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h8,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'hC,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h10,  1, 0, 1, 1, 32'h200, 0, 0, 0, 0);
    do_fetch(32'h100, 0, 2, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    do_fetch(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h80,  2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("final_addr", imem_addr, 32'h84);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
